// File: rtl/multicycle_control_unit_if.sv
// Control-to-datapath bundle: decoded opcode and memory ready handshakes in,
// datapath strobes out.
interface multicycle_control_unit_if;
   logic [3:0] opcode;
   logic       imem_ready;
   logic       dmem_ready;
   logic       ir_load;
   logic       pc_write;
   logic       jump;
   logic       beq;
   logic       bne;
   logic       mem_read;
   logic       mem_write;
   logic       alu_src;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       reg_write;
   logic [2:0] alu_op;

   modport master (
      input  opcode, imem_ready, dmem_ready,
      output ir_load, pc_write, jump, beq, bne,
      output mem_read, mem_write, alu_src, reg_dst,
      output mem_to_reg, reg_write, alu_op
   );

   modport slave (
      output opcode, imem_ready, dmem_ready,
      input  ir_load, pc_write, jump, beq, bne,
      input  mem_read, mem_write, alu_src, reg_dst,
      input  mem_to_reg, reg_write, alu_op
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer for the 16-bit RISC datapath: fetch/decode/exec/
// mem/wb stepping with ready timeouts, sticky faults and a retire counter.
module multicycle_control_unit #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 15
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      run,
   multicycle_control_unit_if.master bus,
   output logic [2:0]                state,
   output logic                      halted,
   output logic                      illegal,
   output logic                      timeout_err,
   output logic [CNT_W-1:0]          instret
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      HALT   = 3'd7
   } state_t;

   localparam logic [3:0] OP_LD  = 4'h0;
   localparam logic [3:0] OP_ST  = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_INV = 4'h4;
   localparam logic [3:0] OP_LSL = 4'h5;
   localparam logic [3:0] OP_LSR = 4'h6;
   localparam logic [3:0] OP_AND = 4'h7;
   localparam logic [3:0] OP_OR  = 4'h8;
   localparam logic [3:0] OP_SLT = 4'h9;
   localparam logic [3:0] OP_BEQ = 4'hB;
   localparam logic [3:0] OP_BNE = 4'hC;
   localparam logic [3:0] OP_JMP = 4'hD;

   localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state_q;
   state_t           state_d;
   logic [7:0]       wait_q;
   logic [3:0]       dec_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ill_q;
   logic             tmo_q;

   logic is_ld, is_st, is_r;
   logic is_beq, is_bne, is_jmp;
   logic op_bad, wait_hit, in_instr;
   logic retire, set_ill, set_tmo;

   logic       ir_load, pc_write;
   logic       jump, beq, bne;
   logic       mem_read, mem_write, reg_write;
   logic       alu_src, reg_dst, mem_to_reg;
   logic [2:0] alu_op;

   assign is_ld    = dec_q == OP_LD;
   assign is_st    = dec_q == OP_ST;
   assign is_r     = dec_q inside {[OP_ADD:OP_SLT]};
   assign is_beq   = dec_q == OP_BEQ;
   assign is_bne   = dec_q == OP_BNE;
   assign is_jmp   = dec_q == OP_JMP;
   assign op_bad   = bus.opcode inside {4'hA, 4'hE, 4'hF};
   assign wait_hit = wait_q == WAIT_LAST;
   assign in_instr = state_q inside {EXEC, MEM, WB};

   // Static decode: held from EXEC until the instruction retires.
   always_comb begin
      alu_src    = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_op     = 3'b000;
      if (in_instr) begin
         alu_src    = is_ld | is_st;
         reg_dst    = is_r;
         mem_to_reg = is_ld;
         case (dec_q)
            OP_SUB, OP_BEQ, OP_BNE: alu_op = 3'b001;
            OP_INV:                 alu_op = 3'b010;
            OP_LSL:                 alu_op = 3'b011;
            OP_LSR:                 alu_op = 3'b100;
            OP_AND:                 alu_op = 3'b101;
            OP_OR:                  alu_op = 3'b110;
            OP_SLT:                 alu_op = 3'b111;
            default:                alu_op = 3'b000;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      retire    = 1'b0;
      set_ill   = 1'b0;
      set_tmo   = 1'b0;
      ir_load   = 1'b0;
      pc_write  = 1'b0;
      jump      = 1'b0;
      beq       = 1'b0;
      bne       = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (run) state_d = FETCH;
         end
         FETCH: begin
            ir_load = 1'b1;
            if (bus.imem_ready) begin
               state_d = DECODE;
            end else if (wait_hit) begin
               state_d = HALT;
               set_tmo = 1'b1;
            end
         end
         DECODE: begin
            if (op_bad) begin
               state_d = HALT;
               set_ill = 1'b1;
            end else begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            unique case (1'b1)
               is_r:           state_d = WB;
               is_ld | is_st:  state_d = MEM;
               default: begin
                  pc_write = 1'b1;
                  jump     = is_jmp;
                  beq      = is_beq;
                  bne      = is_bne;
                  retire   = 1'b1;
               end
            endcase
         end
         MEM: begin
            mem_read  = is_ld;
            mem_write = is_st;
            if (bus.dmem_ready) begin
               if (is_st) begin
                  pc_write = 1'b1;
                  retire   = 1'b1;
               end else begin
                  state_d = WB;
               end
            end else if (wait_hit) begin
               state_d = HALT;
               set_tmo = 1'b1;
            end
         end
         WB: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            retire    = 1'b1;
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // run only matters at an instruction boundary
      if (retire) state_d = run ? FETCH : IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         wait_q  <= '0;
         dec_q   <= '0;
         cnt_q   <= '0;
         ill_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_d != state_q) begin
            wait_q <= '0;
         end else if (state_q inside {FETCH, MEM}) begin
            wait_q <= wait_q + 8'd1;
         end
         if (state_q == DECODE) dec_q <= bus.opcode;
         if (retire) cnt_q <= cnt_q + CNT_ONE;
         if (set_ill) ill_q <= 1'b1;
         if (set_tmo) tmo_q <= 1'b1;
      end
   end

   assign bus.ir_load    = ir_load;
   assign bus.pc_write   = pc_write;
   assign bus.jump       = jump;
   assign bus.beq        = beq;
   assign bus.bne        = bne;
   assign bus.mem_read   = mem_read;
   assign bus.mem_write  = mem_write;
   assign bus.alu_src    = alu_src;
   assign bus.reg_dst    = reg_dst;
   assign bus.mem_to_reg = mem_to_reg;
   assign bus.reg_write  = reg_write;
   assign bus.alu_op     = alu_op;

   assign state       = state_q;
   assign halted      = state_q == HALT;
   assign illegal     = ill_q;
   assign timeout_err = tmo_q;
   assign instret     = cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: instruction-level reference model of the sequencer,
// directed scenarios then randomized instruction streams.
module tb_multicycle_control_unit;
   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 15;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b0;
   logic             run   = 1'b0;
   logic [2:0]       state;
   logic             halted, illegal, timeout_err;
   logic [CNT_W-1:0] instret;

   logic       rst_w = 1'b0;
   logic       run_w = 1'b0;
   logic [2:0] state_w;
   logic       halted_w, illegal_w, timeout_err_w;
   logic [3:0] instret_w;

   multicycle_control_unit_if bus ();
   multicycle_control_unit_if bus_w ();

   multicycle_control_unit #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .bus(bus),
      .state(state), .halted(halted), .illegal(illegal),
      .timeout_err(timeout_err), .instret(instret)
   );

   // narrow counter copy so wrap-around is reachable in few cycles
   multicycle_control_unit #(.CNT_W(4), .TIMEOUT(TIMEOUT)) dut_w (
      .clk(clk), .rst_n(rst_w), .run(run_w), .bus(bus_w),
      .state(state_w), .halted(halted_w), .illegal(illegal_w),
      .timeout_err(timeout_err_w), .instret(instret_w)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   logic [2:0]       e_st;
   logic             e_ir, e_pcw, e_j, e_bq, e_bn;
   logic             e_mr, e_mw, e_rw, e_stat;
   logic             e_h    = 1'b0;
   logic             e_il   = 1'b0;
   logic             e_to   = 1'b0;
   logic             m_idle = 1'b1;
   logic [3:0]       cur_op = 4'h0;
   logic [CNT_W-1:0] m_cnt  = '0;

   // {alu_src, reg_dst, mem_to_reg, alu_op} per instruction
   function automatic logic [5:0] stat_of(input logic [3:0] op);
      case (op)
         4'h0:    return 6'b101_000;
         4'h1:    return 6'b100_000;
         4'h2:    return 6'b010_000;
         4'h3:    return 6'b010_001;
         4'h4:    return 6'b010_010;
         4'h5:    return 6'b010_011;
         4'h6:    return 6'b010_100;
         4'h7:    return 6'b010_101;
         4'h8:    return 6'b010_110;
         4'h9:    return 6'b010_111;
         4'hB:    return 6'b000_001;
         4'hC:    return 6'b000_001;
         default: return 6'b000_000;
      endcase
   endfunction

   task automatic clr();
      e_st   = 3'd0;
      e_ir   = 1'b0;
      e_pcw  = 1'b0;
      e_j    = 1'b0;
      e_bq   = 1'b0;
      e_bn   = 1'b0;
      e_mr   = 1'b0;
      e_mw   = 1'b0;
      e_rw   = 1'b0;
      e_stat = 1'b0;
   endtask

   task automatic chk(input string tag);
      logic [35:0] obs;
      logic [35:0] exp;
      logic [5:0]  s;
      s   = e_stat ? stat_of(cur_op) : 6'd0;
      obs = {state, bus.ir_load, bus.pc_write, bus.jump, bus.beq,
             bus.bne, bus.mem_read, bus.mem_write, bus.alu_src,
             bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_op,
             halted, illegal, timeout_err, instret};
      exp = {e_st, e_ir, e_pcw, e_j, e_bq, e_bn, e_mr, e_mw,
             s[5], s[4], s[3], e_rw, s[2:0], e_h, e_il, e_to, m_cnt};
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s op=%h: observed %h expected %h",
                tag, cur_op, obs, exp);
      end
   endtask

   task automatic chk_v(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      #1;
      rst_n = 1'b0;
      run   = 1'b0;
      #1;
      e_h    = 1'b0;
      e_il   = 1'b0;
      e_to   = 1'b0;
      m_cnt  = '0;
      m_idle = 1'b1;
      clr();
      chk("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic enter_halt(input logic ill);
      if (ill) e_il = 1'b1;
      else e_to = 1'b1;
      e_h = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         run            = i[0];
         bus.imem_ready = 1'b1;
         bus.dmem_ready = i[1];
         #1;
         clr();
         e_st = 3'd7;
         chk("halt");
      end
      do_reset();
   endtask

   // nf/nm: ready wait cycles for fetch/mem, negative = never ready
   task automatic do_instr(input logic [3:0] op, input int nf,
                           input int nm, input logic run_end,
                           input logic stop_exec);
      logic mem_op;
      logic br;
      int   fc;
      int   mc;
      mem_op = (op == 4'h0) || (op == 4'h1);
      br     = op inside {4'hB, 4'hC, 4'hD};
      fc     = (nf < 0) ? TIMEOUT : nf + 1;
      mc     = (nm < 0) ? TIMEOUT : nm + 1;
      cur_op = op;
      if (m_idle) begin
         @(negedge clk);
         run = 1'b1;
         #1;
         clr();
         chk("idle");
         m_idle = 1'b0;
      end
      for (int k = 0; k < fc; k++) begin
         @(negedge clk);
         bus.opcode     = op;
         bus.imem_ready = (k == nf);
         bus.dmem_ready = 1'b0;
         #1;
         clr();
         e_st = 3'd1;
         e_ir = 1'b1;
         chk("fetch");
      end
      if (nf < 0) begin
         enter_halt(1'b0);
         return;
      end
      @(negedge clk);
      bus.imem_ready = 1'b0;
      if (!mem_op) run = run_end;
      #1;
      clr();
      e_st = 3'd2;
      chk("decode");
      if (op inside {4'hA, 4'hE, 4'hF}) begin
         enter_halt(1'b1);
         return;
      end
      @(negedge clk);
      #1;
      clr();
      e_st   = 3'd3;
      e_stat = 1'b1;
      if (br) begin
         e_pcw = 1'b1;
         e_j   = op == 4'hD;
         e_bq  = op == 4'hB;
         e_bn  = op == 4'hC;
      end
      chk("exec");
      if (stop_exec) begin
         do_reset();
         return;
      end
      if (mem_op) begin
         for (int k = 0; k < mc; k++) begin
            @(negedge clk);
            bus.dmem_ready = (k == nm);
            if (k == 0) run = run_end;
            #1;
            clr();
            e_st   = 3'd4;
            e_stat = 1'b1;
            e_mr   = op == 4'h0;
            e_mw   = op == 4'h1;
            e_pcw  = (op == 4'h1) && (k == nm);
            chk("mem");
         end
         if (nm < 0) begin
            enter_halt(1'b0);
            return;
         end
      end
      if (op != 4'h1 && !br) begin
         @(negedge clk);
         bus.dmem_ready = 1'b0;
         #1;
         clr();
         e_st   = 3'd5;
         e_stat = 1'b1;
         e_rw   = 1'b1;
         e_pcw  = 1'b1;
         chk("wb");
      end
      m_cnt  = m_cnt + 1'b1;
      m_idle = !run_end;
   endtask

   initial begin
      logic [3:0] legal [13];
      logic [3:0] op;
      int         retired;
      int         last;
      int         cyc;
      legal = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                4'h7, 4'h8, 4'h9, 4'hB, 4'hC, 4'hD};
      bus.opcode       = 4'h0;
      bus.imem_ready   = 1'b0;
      bus.dmem_ready   = 1'b0;
      bus_w.opcode     = 4'h2;
      bus_w.imem_ready = 1'b1;
      bus_w.dmem_ready = 1'b0;

      @(negedge clk);
      #1;
      clr();
      chk("por");
      @(negedge clk);
      rst_n = 1'b1;

      do_instr(4'h2, 0, 0, 1'b1, 1'b0);
      do_instr(4'h0, 0, 3, 1'b1, 1'b0);
      do_instr(4'hB, 0, 0, 1'b1, 1'b0);
      do_instr(4'hD, 0, 0, 1'b0, 1'b0);
      do_instr(4'hE, 0, 0, 1'b1, 1'b0);
      do_instr(4'h1, 0, -1, 1'b1, 1'b0);
      do_instr(4'h0, 1, 2, 1'b0, 1'b0);
      repeat (2) begin
         @(negedge clk);
         #1;
         clr();
         chk("idle_hold");
      end
      do_instr(4'hC, 0, 0, 1'b1, 1'b1);
      do_instr(4'h2, -1, 0, 1'b1, 1'b0);
      do_instr(4'hA, 2, 0, 1'b1, 1'b0);
      do_instr(4'hF, 0, 0, 1'b1, 1'b0);

      for (int i = 0; i < 40; i++) begin
         op = legal[$urandom_range(0, 12)];
         do_instr(op, $urandom_range(0, 2), $urandom_range(0, 3),
                  $urandom_range(0, 3) != 0, 1'b0);
      end

      @(negedge clk);
      rst_w = 1'b1;
      run_w = 1'b1;
      retired = 0;
      last    = 0;
      cyc     = 0;
      while (retired < 17 && cyc < 120) begin
         @(negedge clk);
         #1;
         cyc++;
         if (bus_w.pc_write) begin
            chk_v("wrap_cnt", int'(instret_w), retired % 16);
            if (retired > 0) chk_v("wrap_gap", cyc - last, 4);
            last = cyc;
            retired++;
         end
      end
      chk_v("wrap_done", retired, 17);
      @(negedge clk);
      #1;
      chk_v("wrap_end", int'(instret_w), 1);
      chk_v("wrap_state",
            int'({halted_w, illegal_w, timeout_err_w, state_w}), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
